// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt sequencer for the CPU's slow clock-enable.
// RUN divides clk by a programmable ratio, STOP emits one pulse per debounced press, HALT freezes.
module cpu_clk_ctrl #(
    parameter int                 DIV_W       = 16,
    parameter logic [DIV_W-1:0]   DEFAULT_DIV = 16'd5000,
    parameter logic [15:0]        DEBOUNCE    = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             div_load,
    output logic             cpu_ce,
    output logic             clk_slow,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           st;
    logic             run_m, run_s, btn_m, btn_s;
    logic             db_level, db_prev;
    logic [15:0]      db_cnt;
    logic [DIV_W-1:0] div_reg, cnt;
    logic             step_evt, tc, fire;

    assign state    = st;
    assign step_evt = db_level & ~db_prev;
    assign tc       = (cnt == div_reg - ONE);

    // Synchronizers and button debounce
    always_ff @(posedge clk) begin
        if (reset) begin
            run_m    <= 1'b0;
            run_s    <= 1'b0;
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            run_m   <= run_sw;
            run_s   <= run_m;
            btn_m   <= step_btn;
            btn_s   <= btn_m;
            db_prev <= db_level;
            if (btn_s == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DEBOUNCE - 16'd1) begin
                db_level <= btn_s;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 16'd1;
            end
        end
    end

    // halt wins over any pulse source; a load on terminal count eats that pulse
    always_comb begin
        fire = 1'b0;
        if (!halt) begin
            case (st)
                ST_RUN:  fire = tc && !div_load;
                ST_STOP: fire = step_evt;
                default: fire = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= ST_STOP;
            cpu_ce   <= 1'b0;
            clk_slow <= 1'b0;
            cnt      <= '0;
            div_reg  <= DEFAULT_DIV;
        end else begin
            cpu_ce <= fire;
            if (fire)
                clk_slow <= ~clk_slow;

            if (div_load) begin
                div_reg <= (div_cfg == '0) ? ONE : div_cfg;
                cnt     <= '0;
            end else if (st != ST_RUN || tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end

            case (st)
                ST_STOP: begin
                    if (halt)       st <= ST_HALT;
                    else if (run_s) st <= ST_RUN;
                end
                ST_RUN: begin
                    if (halt)        st <= ST_HALT;
                    else if (!run_s) st <= ST_STOP;
                end
                default: st <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with DEFAULT_DIV=5, DEBOUNCE=4.
module tb_cpu_clk_ctrl;

    logic        clk = 1'b0;
    logic        reset, run_sw, step_btn, halt, div_load;
    logic [15:0] div_cfg;
    logic        cpu_ce, clk_slow;
    logic [1:0]  state;
    logic        exp_slow;
    int          n_chk = 0;
    int          n_err = 0;

    cpu_clk_ctrl #(
        .DIV_W       (16),
        .DEFAULT_DIV (16'd5),
        .DEBOUNCE    (16'd4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .halt     (halt),
        .div_cfg  (div_cfg),
        .div_load (div_load),
        .cpu_ce   (cpu_ce),
        .clk_slow (clk_slow),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // advance n edges, land 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // n pulses of period d, starting right after a pulse or load edge
    task automatic run_period(input int d, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < d - 1; i++) begin
                tick(1);
                chk("ce_idle", 32'(cpu_ce), 32'd0);
            end
            tick(1);
            exp_slow = ~exp_slow;
            chk("ce_pulse", 32'(cpu_ce), 32'd1);
            chk("clk_slow", 32'(clk_slow), 32'(exp_slow));
        end
    endtask

    initial begin
        logic [3:0] bounce;
        bounce   = 4'b0101;
        reset    = 1'b1;
        run_sw   = 1'b0;
        step_btn = 1'b0;
        halt     = 1'b0;
        div_load = 1'b0;
        div_cfg  = 16'd0;
        exp_slow = 1'b0;
        tick(2);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ce", 32'(cpu_ce), 32'd0);
        chk("rst_slow", 32'(clk_slow), 32'd0);

        // RUN entry: state on the third edge, first pulse div edges later
        reset  = 1'b0;
        run_sw = 1'b1;
        tick(2);
        chk("run_lag2", 32'(state), 32'd0);
        tick(1);
        chk("run_edge3", 32'(state), 32'd1);
        run_period(5, 2);

        // div_cfg=0 stores 1: pulse every cycle
        div_cfg = 16'd0; div_load = 1'b1;
        tick(1);
        div_load = 1'b0;
        chk("load0_edge", 32'(cpu_ce), 32'd0);
        run_period(1, 4);

        // load 3 on a terminal-count cycle suppresses that pulse
        div_cfg = 16'd3; div_load = 1'b1;
        tick(1);
        div_load = 1'b0;
        chk("load_tc_supp", 32'(cpu_ce), 32'd0);
        run_period(3, 3);

        // button activity in RUN leaves the period unchanged
        fork
            begin
                step_btn = 1'b1;
                repeat (10) @(posedge clk);
                #1 step_btn = 1'b0;
            end
            run_period(3, 7);
        join

        // back to div=5, then reset mid-count
        div_cfg = 16'd5; div_load = 1'b1;
        tick(1);
        div_load = 1'b0;
        chk("load5_edge", 32'(cpu_ce), 32'd0);
        run_period(5, 1);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_slow = 1'b0;
        chk("midrst_ce", 32'(cpu_ce), 32'd0);
        chk("midrst_slow", 32'(clk_slow), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        tick(2);
        chk("rerun_lag", 32'(state), 32'd0);
        tick(1);
        chk("rerun_state", 32'(state), 32'd1);
        run_period(5, 2);

        // STOP
        run_sw = 1'b0;
        tick(3);
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_ce", 32'(cpu_ce), 32'd0);

        // bouncy press then stable high: one pulse 7 edges after driving 1
        for (int i = 0; i < 4; i++) begin
            step_btn = bounce[i];
            tick(1);
            chk("bounce_ce", 32'(cpu_ce), 32'd0);
        end
        step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            chk("step_ce", 32'(cpu_ce), (i == 7) ? 32'd1 : 32'd0);
            if (i == 7) begin
                exp_slow = ~exp_slow;
                chk("step_slow", 32'(clk_slow), 32'(exp_slow));
            end
        end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("release_ce", 32'(cpu_ce), 32'd0);
        end

        // 3-cycle glitch is shorter than DEBOUNCE
        step_btn = 1'b1;
        tick(3);
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("glitch_ce", 32'(cpu_ce), 32'd0);
        end

        // halt one cycle before terminal count
        run_sw = 1'b1;
        tick(3);
        chk("run2_state", 32'(state), 32'd1);
        tick(3);
        halt = 1'b1;
        tick(1);
        chk("halt_state", 32'(state), 32'd2);
        chk("halt_ce", 32'(cpu_ce), 32'd0);
        halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            run_sw   = (i % 6) < 3;
            step_btn = (i >= 5) && (i < 15);
            tick(1);
            chk("halt_sticky", 32'(state), 32'd2);
            chk("halt_noce", 32'(cpu_ce), 32'd0);
            chk("halt_slow", 32'(clk_slow), 32'(exp_slow));
        end

        // halt rising on the terminal-count cycle kills that pulse
        reset = 1'b1;
        tick(1);
        reset    = 1'b0;
        run_sw   = 1'b1;
        step_btn = 1'b0;
        exp_slow = 1'b0;
        chk("rst2_state", 32'(state), 32'd0);
        tick(3);
        chk("run3_state", 32'(state), 32'd1);
        tick(4);
        halt = 1'b1;
        tick(1);
        chk("halt_tc_supp", 32'(cpu_ce), 32'd0);
        chk("halt_tc_state", 32'(state), 32'd2);
        halt = 1'b0;
        tick(1);
        chk("halt_tc_after", 32'(cpu_ce), 32'd0);

        reset = 1'b1;
        tick(1);
        chk("final_state", 32'(state), 32'd0);
        chk("final_slow", 32'(clk_slow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
